// File: rtl/vector_output_serializer.sv
// Vector FIFO plus lane serializer: buffers CPU output vectors and streams them
// out one byte per handshake. Optional frame marker byte under VEC_OUT_MARKER_EN.
module vector_output_serializer #(
   parameter int VECTOR_SIZE  = 8,
   parameter int OUTPUT_WIDTH = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0]   vecIn,
   input  logic                                  vecValid,
   input  logic                                  byteReady,
   input  logic                                  clearOverflow,
   output logic [OUTPUT_WIDTH-1:0]               byteOut,
   output logic                                  byteValid,
   output logic                                  frameLast,
   output logic                                  fifoFull,
   output logic                                  fifoEmpty,
   output logic [$clog2(FIFO_DEPTH):0]           level,
   output logic                                  overflow
);

   localparam int VW = VECTOR_SIZE * OUTPUT_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int IW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

`ifdef VEC_OUT_MARKER_EN
   localparam logic [OUTPUT_WIDTH-1:0] MARKER = OUTPUT_WIDTH'(8'hA5);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_MARK = 2'd2} state_t;
   localparam state_t S_FIRST = S_MARK;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1} state_t;
   localparam state_t S_FIRST = S_SEND;
`endif

   state_t              r_state;
   logic [VW-1:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [LW-1:0]       r_level;
   logic [VW-1:0]       r_shift;
   logic [IW-1:0]       r_idx;
   logic [OUTPUT_WIDTH-1:0] r_byte;
   logic                r_valid;
   logic                r_last;
   logic                r_full;
   logic                r_empty;
   logic                r_ovf;

   state_t              w_state_n;
   logic [VW-1:0]       w_shift_n;
   logic [IW-1:0]       w_idx_n;
   logic                w_hs;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic [LW-1:0]       w_level_n;
   logic [OUTPUT_WIDTH-1:0] w_byte_n;
   logic                w_valid_n;
   logic                w_last_n;

   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_idx_n   = r_idx;
      w_pop     = 1'b0;
      w_hs      = r_valid & byteReady;
      case (r_state)
         S_IDLE: begin
            if (r_level != '0) begin
               w_pop     = 1'b1;
               w_shift_n = r_mem[r_rptr];
               w_idx_n   = '0;
               w_state_n = S_FIRST;
            end
         end
`ifdef VEC_OUT_MARKER_EN
         S_MARK: begin
            if (w_hs) w_state_n = S_SEND;
         end
`endif
         S_SEND: begin
            if (w_hs) begin
               if (r_idx != LAST_IDX) begin
                  w_idx_n = r_idx + 1'b1;
               end else if (r_level != '0) begin
                  // Reload straight from the FIFO so frames run back-to-back.
                  w_pop     = 1'b1;
                  w_shift_n = r_mem[r_rptr];
                  w_idx_n   = '0;
                  w_state_n = S_FIRST;
               end else begin
                  w_state_n = S_IDLE;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase

      w_push    = vecValid && ((r_level != FULL_LVL) || w_pop);
      w_drop    = vecValid && !w_push;
      w_level_n = r_level + LW'(w_push) - LW'(w_pop);

      // Outputs are registered from the next state, so they hold while stalled.
      w_valid_n = (w_state_n != S_IDLE);
      w_byte_n  = '0;
      w_last_n  = 1'b0;
      if (w_state_n == S_SEND) begin
         for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
            if (w_idx_n == IW'(i)) w_byte_n = w_shift_n[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
         end
         w_last_n = (w_idx_n == LAST_IDX);
      end
`ifdef VEC_OUT_MARKER_EN
      else if (w_state_n == S_MARK) begin
         w_byte_n = MARKER;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_byte  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_shift <= w_shift_n;
         r_idx   <= w_idx_n;
         r_byte  <= w_byte_n;
         r_valid <= w_valid_n;
         r_last  <= w_last_n;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= vecIn;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_level <= w_level_n;
         r_full  <= (w_level_n == FULL_LVL);
         r_empty <= (w_level_n == '0);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)              r_ovf <= 1'b0;
      else if (w_drop)        r_ovf <= 1'b1;
      else if (clearOverflow) r_ovf <= 1'b0;
   end

   assign byteOut   = r_byte;
   assign byteValid = r_valid;
   assign frameLast = r_last;
   assign fifoFull  = r_full;
   assign fifoEmpty = r_empty;
   assign level     = r_level;
   assign overflow  = r_ovf;

endmodule
